sprite_hit_scheduler: RTL and testbench

Sequences the per-pixel sprite search for the sprite pipeline. It owns the 32-entry sprite attribute table (anchor X/Y, layer), scans it one slot per cycle against a captured H/V pixel position, and collects up to four hits in priority order. The hits are handed to the sprite memory controller over a valid/ready handshake. Configuration writes from the game logic are arbitrated against the scan.

---
 rtl/sprite_pkg.sv | 39 +++
 rtl/sprite_bbox_hit.sv | 14 +
 rtl/sprite_hit_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_sprite_hit_scheduler.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and constants for the sprite hit scheduler.
//   NUM_SPRITES / SPRITE_SIZE / MAX_HITS / COORD_W / LAYER_W : table geometry
//   NO_SPRITE_ID   : layer value that marks a slot as disabled or unused
//   sprite_attr_t  : one attribute-table entry {x, y, layer}
//   sched_state_e  : scheduler FSM states
//   in_span()      : half-open range test anchor <= pos < anchor + SPRITE_SIZE
package sprite_pkg;
    localparam int NUM_SPRITES = 32;
    localparam int SPRITE_SIZE = 16;
    localparam int MAX_HITS    = 4;
    localparam int COORD_W     = 10;
    localparam int LAYER_W     = 6;
    localparam int IDX_W       = 5;
    localparam int CNT_W       = 3;
    localparam int BND_W       = COORD_W + 1;

    localparam logic [LAYER_W-1:0] NO_SPRITE_ID = 6'h3F;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [LAYER_W-1:0] layer;
    } sprite_attr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        OUT  = 2'd2
    } sched_state_e;

    // The upper bound is formed one bit wider so anchors near the top of the
    // coordinate range clip at the edge instead of wrapping back to zero.
    function automatic logic in_span(input logic [COORD_W-1:0] anchor,
                                     input logic [COORD_W-1:0] pos);
        logic [BND_W-1:0] upper;
        upper = {1'b0, anchor} + BND_W'(SPRITE_SIZE);
        return (pos >= anchor) && ({1'b0, pos} < upper);
    endfunction
endpackage

// File: rtl/sprite_bbox_hit.sv
// sprite_bbox_hit: combinational test of one attribute entry against a pixel.
//   attr : attribute entry under test
//   h, v : pixel position
//   hit  : entry enabled and the pixel lies inside its SPRITE_SIZE square
module sprite_bbox_hit
    import sprite_pkg::*;
(
    input  sprite_attr_t       attr,
    input  logic [COORD_W-1:0] h,
    input  logic [COORD_W-1:0] v,
    output logic               hit
);
    assign hit = (attr.layer != NO_SPRITE_ID) && in_span(attr.x, h) && in_span(attr.y, v);
endmodule

// File: rtl/sprite_hit_scheduler.sv
// sprite_hit_scheduler: owns the 32-entry sprite attribute table, scans it
// slot 31 down to 0 against a captured pixel position and collects up to
// MAX_HITS hits in priority order for the sprite memory controller.
//   clk, rst (async, active-low)
//   start, h_pos, v_pos, busy             : scan request / status
//   cfg_we, cfg_ready, cfg_idx/x/y/layer  : attribute writes (stalled in SCAN)
//   hit_valid, hit_ready                  : result handshake
//   hit_count, hit_slot, hit_layer, hit_overflow : results
// Build option: SPRITE_SCHED_OVERFLOW_EN -- scan all slots and flag hits
// beyond MAX_HITS on hit_overflow; otherwise the scan stops at MAX_HITS hits.
module sprite_hit_scheduler
    import sprite_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COORD_W-1:0] h_pos,
    input  logic [COORD_W-1:0] v_pos,
    output logic               busy,
    input  logic               cfg_we,
    output logic               cfg_ready,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [COORD_W-1:0] cfg_x,
    input  logic [COORD_W-1:0] cfg_y,
    input  logic [LAYER_W-1:0] cfg_layer,
    output logic               hit_valid,
    input  logic               hit_ready,
    output logic [CNT_W-1:0]   hit_count,
    output logic [IDX_W-1:0]   hit_slot  [MAX_HITS],
    output logic [LAYER_W-1:0] hit_layer [MAX_HITS],
    output logic               hit_overflow
);
    sched_state_e       state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [COORD_W-1:0] h_q, h_d, v_q, v_d;
    sprite_attr_t       table_q [NUM_SPRITES];
    sprite_attr_t       table_d [NUM_SPRITES];
    logic [IDX_W-1:0]   slot_q  [MAX_HITS];
    logic [IDX_W-1:0]   slot_d  [MAX_HITS];
    logic [LAYER_W-1:0] layer_q [MAX_HITS];
    logic [LAYER_W-1:0] layer_d [MAX_HITS];
    logic [CNT_W-1:0]   count_q, count_d;
    logic               busy_q, busy_d, valid_q, valid_d, cfg_ready_q, cfg_ready_d;
    logic               ovf_q, ovf_d;
    logic               last_s, cfg_accept_s, scan_hit_s;
    sprite_attr_t       scan_attr_s;

    assign scan_attr_s  = table_q[idx_q];
    assign cfg_accept_s = cfg_we && cfg_ready_q;

    sprite_bbox_hit u_bbox (
        .attr (scan_attr_s),
        .h    (h_q),
        .v    (v_q),
        .hit  (scan_hit_s)
    );

    // Attribute table write port; cfg_ready is already low during SCAN.
    always_comb begin
        table_d = table_q;
        if (cfg_accept_s) begin
            table_d[cfg_idx] = '{x: cfg_x, y: cfg_y, layer: cfg_layer};
        end else begin
            table_d[cfg_idx] = table_q[cfg_idx];
        end
    end

    // Scan FSM, hit collection and next-state registered outputs.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        h_d     = h_q;
        v_d     = v_q;
        slot_d  = slot_q;
        layer_d = layer_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        last_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    idx_d   = IDX_W'(NUM_SPRITES - 1);
                    h_d     = h_pos;
                    v_d     = v_pos;
                    count_d = {CNT_W{1'b0}};
                    ovf_d   = 1'b0;
                    for (int i = 0; i < MAX_HITS; i++) begin
                        slot_d[i]  = {IDX_W{1'b0}};
                        layer_d[i] = NO_SPRITE_ID;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                if (scan_hit_s && (count_q < CNT_W'(MAX_HITS))) begin
                    slot_d[count_q[1:0]]  = idx_q;
                    layer_d[count_q[1:0]] = scan_attr_s.layer;
                    count_d               = count_q + 3'd1;
                end else if (scan_hit_s) begin
`ifdef SPRITE_SCHED_OVERFLOW_EN
                    ovf_d = 1'b1;
`else
                    ovf_d = 1'b0;
`endif
                end else begin
                    count_d = count_q;
                end
`ifdef SPRITE_SCHED_OVERFLOW_EN
                last_s = (idx_q == {IDX_W{1'b0}});
`else
                last_s = (idx_q == {IDX_W{1'b0}}) ||
                         (scan_hit_s && (count_q == CNT_W'(MAX_HITS - 1)));
`endif
                if (last_s) begin
                    state_d = OUT;
                end else begin
                    idx_d = idx_q - 5'd1;
                end
            end
            OUT: begin
                if (hit_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d      = (state_d != IDLE);
        valid_d     = (state_d == OUT);
        cfg_ready_d = (state_d != SCAN);
    end

    // State, table and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= {IDX_W{1'b0}};
            h_q         <= {COORD_W{1'b0}};
            v_q         <= {COORD_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            cfg_ready_q <= 1'b1;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                table_q[i] <= '{x: {COORD_W{1'b0}}, y: {COORD_W{1'b0}}, layer: NO_SPRITE_ID};
            end
            for (int i = 0; i < MAX_HITS; i++) begin
                slot_q[i]  <= {IDX_W{1'b0}};
                layer_q[i] <= NO_SPRITE_ID;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            h_q         <= h_d;
            v_q         <= v_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            cfg_ready_q <= cfg_ready_d;
            table_q     <= table_d;
            slot_q      <= slot_d;
            layer_q     <= layer_d;
        end
    end

    assign busy         = busy_q;
    assign hit_valid    = valid_q;
    assign cfg_ready    = cfg_ready_q;
    assign hit_count    = count_q;
    assign hit_slot     = slot_q;
    assign hit_layer    = layer_q;
    assign hit_overflow = ovf_q;
endmodule

// File: tb/tb_sprite_hit_scheduler.sv
// Self-checking bench for sprite_hit_scheduler: a reference table model
// predicts each scan result, which is queued at start and compared when
// hit_valid rises.
module tb_sprite_hit_scheduler;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [9:0] h_pos = 10'd0, v_pos = 10'd0;
    logic       busy;
    logic       cfg_we = 1'b0;
    logic       cfg_ready;
    logic [4:0] cfg_idx = 5'd0;
    logic [9:0] cfg_x = 10'd0, cfg_y = 10'd0;
    logic [5:0] cfg_layer = 6'h3F;
    logic       hit_valid;
    logic       hit_ready = 1'b0;
    logic [2:0] hit_count;
    logic [4:0] hit_slot  [4];
    logic [5:0] hit_layer [4];
    logic       hit_overflow;

    typedef struct {
        int             lat;
        logic [2:0]     cnt;
        logic [3:0][4:0] slot;
        logic [3:0][5:0] layer;
        logic           ovf;
    } exp_t;

    exp_t sb[$];
    exp_t last_exp;
    int   m_x [32];
    int   m_y [32];
    int   m_l [32];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    sprite_hit_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .h_pos(h_pos), .v_pos(v_pos),
        .busy(busy), .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
        .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_layer(cfg_layer),
        .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_count(hit_count),
        .hit_slot(hit_slot), .hit_layer(hit_layer), .hit_overflow(hit_overflow)
    );

    task automatic model_reset();
        for (int s = 0; s < 32; s++) begin
            m_x[s] = 0; m_y[s] = 0; m_l[s] = 63;
        end
    endtask

    task automatic model_scan(input int h, input int v, output exp_t e);
        int n;
        n = 0;
        e.lat = 32; e.cnt = 3'd0; e.ovf = 1'b0;
        for (int k = 0; k < 4; k++) begin
            e.slot[k] = 5'd0; e.layer[k] = 6'h3F;
        end
        for (int s = 31; s >= 0; s--) begin
            if ((m_l[s] != 63) && (m_x[s] <= h) && (h < m_x[s] + 16) &&
                (m_y[s] <= v) && (v < m_y[s] + 16)) begin
                if (n < 4) begin
                    e.slot[n]  = 5'(s);
                    e.layer[n] = 6'(m_l[s]);
                end
                n++;
`ifndef SPRITE_SCHED_OVERFLOW_EN
                if (n == 4 && e.lat == 32) e.lat = 32 - s;
`endif
            end
        end
        e.cnt = (n > 4) ? 3'd4 : 3'(n);
`ifdef SPRITE_SCHED_OVERFLOW_EN
        e.ovf = (n > 4);
`endif
    endtask

    task automatic write_slot(input int idx, input int x, input int y, input int layer);
        tests++;
        if (cfg_ready !== 1'b1) begin
            fails++;
            $display("FAIL cfg_ready_idle: got %b want 1", cfg_ready);
        end
        cfg_we = 1'b1; cfg_idx = 5'(idx); cfg_x = 10'(x); cfg_y = 10'(y); cfg_layer = 6'(layer);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_x[idx] = x; m_y[idx] = y; m_l[idx] = layer;
    endtask

    task automatic start_scan(input int h, input int v);
        exp_t e;
        model_scan(h, v, e);
        sb.push_back(e);
        h_pos = 10'(h); v_pos = 10'(v); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (hit_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        tests++;
        if (lat == 0) begin
            fails++;
            $display("FAIL valid_timeout: hit_valid not seen within 40 cycles");
        end
    endtask

    task automatic check_outputs(input exp_t e, input string tag);
        tests++;
        if (hit_count !== e.cnt) begin
            fails++; $display("FAIL %s count: got %0d want %0d", tag, hit_count, e.cnt);
        end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (hit_slot[k] !== e.slot[k] || hit_layer[k] !== e.layer[k]) begin
                fails++;
                $display("FAIL %s entry%0d: got slot %0d layer %h want slot %0d layer %h",
                         tag, k, hit_slot[k], hit_layer[k], e.slot[k], e.layer[k]);
            end
        end
        tests++;
        if (hit_overflow !== e.ovf || busy !== 1'b1 || hit_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s flags: got ovf %b busy %b valid %b want ovf %b busy 1 valid 1",
                     tag, hit_overflow, busy, hit_valid, e.ovf);
        end
    endtask

    task automatic check_result(input int lat, input string tag);
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++; $display("FAIL %s scoreboard: empty queue", tag);
        end else begin
            e = sb.pop_front();
            last_exp = e;
            if (lat != e.lat) begin
                fails++; $display("FAIL %s latency: got %0d want %0d", tag, lat, e.lat);
            end
            check_outputs(e, tag);
        end
    endtask

    task automatic accept();
        hit_ready = 1'b1;
        @(posedge clk); #1;
        hit_ready = 1'b0;
        tests++;
        if (hit_valid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL accept: got valid %b busy %b want 0 0", hit_valid, busy);
        end
    endtask

    task automatic run_scan(input int h, input int v, input string tag);
        int lat;
        start_scan(h, v);
        wait_valid(lat);
        check_result(lat, tag);
        accept();
    endtask

    task automatic check_reset_outputs(input string tag);
        tests++;
        if (busy !== 1'b0 || hit_valid !== 1'b0 || hit_overflow !== 1'b0 ||
            hit_count !== 3'd0 || cfg_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s flags: got busy %b valid %b ovf %b count %0d rdy %b want 0 0 0 0 1",
                     tag, busy, hit_valid, hit_overflow, hit_count, cfg_ready);
        end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (hit_slot[k] !== 5'd0 || hit_layer[k] !== 6'h3F) begin
                fails++;
                $display("FAIL %s entry%0d: got slot %0d layer %h want 0 3f",
                         tag, k, hit_slot[k], hit_layer[k]);
            end
        end
    endtask

    task automatic test_reset();
        model_reset();
        #12;
        check_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_empty();
        run_scan(0, 0, "empty");
    endtask

    task automatic test_two_hits();
        write_slot(5, 100, 50, 2);
        write_slot(20, 108, 58, 7);
        run_scan(110, 60, "two_hits");
        run_scan(115, 65, "last_pixel");
        run_scan(116, 66, "excl_bound");
    endtask

    task automatic test_priority();
        write_slot(5, 0, 0, 63);
        write_slot(20, 0, 0, 63);
        for (int s = 31; s >= 26; s--) write_slot(s, 0, 0, s - 16);
        run_scan(3, 3, "priority");
    endtask

    task automatic test_no_wrap();
        for (int s = 31; s >= 26; s--) write_slot(s, 0, 0, 63);
        write_slot(0, 1020, 0, 9);
        run_scan(1023, 5, "edge_hit");
        run_scan(3, 5, "no_wrap");
    endtask

    task automatic test_cfg_stall();
        int e;
        int bad;
        e = 0; bad = 0;
        start_scan(203, 203);
        while (e < 40) begin
            @(posedge clk); #1;
            e++;
            if (hit_valid === 1'b1) break;
            if (e == 2) begin
                cfg_we = 1'b1; cfg_idx = 5'd10; cfg_x = 10'd200; cfg_y = 10'd200; cfg_layer = 6'd4;
            end
            if (cfg_ready !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL cfg_stall: cfg_ready high in %0d scan cycles, want 0", bad);
        end
        check_result(e, "stall_scan");
        tests++;
        if (cfg_ready !== 1'b1) begin
            fails++; $display("FAIL cfg_ready_out: got %b want 1", cfg_ready);
        end
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_x[10] = 200; m_y[10] = 200; m_l[10] = 4;
        accept();
        run_scan(203, 203, "after_stall");
    endtask

    task automatic test_hold();
        int lat;
        start_scan(205, 210);
        wait_valid(lat);
        check_result(lat, "hold");
        start = 1'b1; h_pos = 10'd1021; v_pos = 10'd1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check_outputs(last_exp, "hold_stable");
        end
        start = 1'b0;
        accept();
    endtask

    task automatic test_reset_midscan();
        exp_t junk;
        write_slot(15, 500, 500, 12);
        start_scan(505, 505);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        junk = sb.pop_front();
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        run_scan(505, 505, "rst_table");
        run_scan(1023, 5, "rst_table2");
    endtask

    initial begin
        test_reset();
        test_empty();
        test_two_hits();
        test_priority();
        test_no_wrap();
        test_cfg_stall();
        test_hold();
        test_reset_midscan();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
